// File: rtl/snoop_bus_sequencer.sv
// rtl/snoop_bus_sequencer.sv - snoopy bus sequencer: arbitration, timed snoop window, grant-hold limit
module snoop_bus_sequencer #(
    parameter int NUMBER_OF_DEVICES = 4,
    parameter int ARBITRATION_MODE  = 0,
    parameter int SNOOP_WINDOW      = 2,
    parameter int MAX_HOLD_CYCLES   = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUMBER_OF_DEVICES-1:0]         requests,
    input  logic                                 commandValid,
    input  logic [NUMBER_OF_DEVICES-1:0]         sharedOuts,
    output logic [NUMBER_OF_DEVICES-1:0]         grants,
    output logic [$clog2(NUMBER_OF_DEVICES)-1:0] grantedIndex,
    output logic                                 busy,
    output logic                                 sharedIn,
    output logic                                 snoopDone,
    output logic                                 timeout
);
    localparam int IW = $clog2(NUMBER_OF_DEVICES);
    localparam int HW = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
    localparam int WW = (SNOOP_WINDOW > 1) ? $clog2(SNOOP_WINDOW) : 1;
    localparam bit HOLD_ENABLED = (MAX_HOLD_CYCLES > 0);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_ENABLED ? MAX_HOLD_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WINDOW_LAST = WW'(SNOOP_WINDOW - 1);
    localparam logic [IW-1:0] LAST_DEVICE = IW'(NUMBER_OF_DEVICES - 1);

    typedef enum logic [1:0] {IDLE, GRANTED, SNOOP} stateType;

    stateType      state;
    logic [IW-1:0] rrPointer;
    logic [HW-1:0] holdCount;
    logic [WW-1:0] windowCount;
    logic          accumulator;
    logic [IW-1:0] winnerIdx;
    logic          holdExpired;
    logic          anyShared;

    // Search order starts at the pointer in round-robin mode, at index 0 in fixed-priority mode.
    function automatic logic [IW-1:0] pickWinner(input logic [NUMBER_OF_DEVICES-1:0] req,
                                                 input logic [IW-1:0] ptr);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NUMBER_OF_DEVICES; i++) begin
            idx = (ARBITRATION_MODE == 1) ? i : (int'(ptr) + i) % NUMBER_OF_DEVICES;
            if (!found && req[idx]) begin
                found = 1'b1;
                w     = IW'(idx);
            end
        end
        return w;
    endfunction

    assign winnerIdx   = pickWinner(requests, rrPointer);
    assign holdExpired = HOLD_ENABLED && (holdCount == HOLD_LAST);
    assign anyShared   = |sharedOuts;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            grants       <= '0;
            grantedIndex <= '0;
            busy         <= 1'b0;
            sharedIn     <= 1'b0;
            snoopDone    <= 1'b0;
            timeout      <= 1'b0;
            rrPointer    <= '0;
            holdCount    <= '0;
            windowCount  <= '0;
            accumulator  <= 1'b0;
        end else begin
            snoopDone <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|requests) begin
                        state        <= GRANTED;
                        grants       <= {{(NUMBER_OF_DEVICES-1){1'b0}}, 1'b1} << winnerIdx;
                        grantedIndex <= winnerIdx;
                        busy         <= 1'b1;
                        holdCount    <= '0;
                        if (ARBITRATION_MODE == 0)
                            rrPointer <= (winnerIdx == LAST_DEVICE) ? '0 : winnerIdx + 1'b1;
                    end
                end
                GRANTED, SNOOP: begin
                    // The hold limit overrides both a window close and a release in the same cycle.
                    if (holdExpired) begin
                        state     <= IDLE;
                        grants    <= '0;
                        busy      <= 1'b0;
                        holdCount <= '0;
                        timeout   <= 1'b1;
                    end else begin
                        holdCount <= holdCount + 1'b1;
                        if (state == SNOOP) begin
                            if (windowCount == WINDOW_LAST) begin
                                sharedIn  <= accumulator | anyShared;
                                snoopDone <= 1'b1;
                                state     <= GRANTED;
                            end else begin
                                accumulator <= accumulator | anyShared;
                                windowCount <= windowCount + 1'b1;
                            end
                        end else if (!requests[grantedIndex]) begin
                            state     <= IDLE;
                            grants    <= '0;
                            busy      <= 1'b0;
                            holdCount <= '0;
                        end else if (commandValid) begin
                            state       <= SNOOP;
                            accumulator <= 1'b0;
                            windowCount <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
